// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port among NUM_MASTERS masters, holding grant for a whole cyc.
// Optional bus watchdog enabled by defining WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADR_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0]              m_cyc,
  input  logic [NUM_MASTERS-1:0]              m_stb,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]    m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_ms,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel,
  input  logic [NUM_MASTERS*3-1:0]            m_cti,
  input  logic [NUM_MASTERS*2-1:0]            m_bte,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_rty,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [DATA_WIDTH-1:0]               m_dat_sm,
  output logic                                s_cyc,
  output logic                                s_stb,
  output logic                                s_we,
  output logic [ADR_WIDTH-1:0]                s_adr,
  output logic [DATA_WIDTH-1:0]               s_dat_ms,
  output logic [DATA_WIDTH/8-1:0]             s_sel,
  output logic [2:0]                          s_cti,
  output logic [1:0]                          s_bte,
  input  logic                                s_ack,
  input  logic                                s_rty,
  input  logic                                s_err,
  input  logic [DATA_WIDTH-1:0]               s_dat_sm,
  output logic [NUM_MASTERS-1:0]              grant
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_WIDTH:0]   NUM_M_W  = (IDX_WIDTH+1)'(NUM_MASTERS);
  localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   gidx_q, gidx_d;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic [IDX_WIDTH-1:0]   pick_s;
  logic [IDX_WIDTH:0]     cand_s;
  logic                   found_s;
  logic                   resp_s;
  logic                   timeout_s;

  assign resp_s   = s_ack | s_rty | s_err;
  assign grant    = grant_q;
  assign m_dat_sm = s_dat_sm;

  // Rotating-priority search: first requester after the last owner, wrapping modulo NUM_MASTERS.
  always_comb begin
    pick_s  = last_q;
    found_s = 1'b0;
    cand_s  = {(IDX_WIDTH+1){1'b0}};
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand_s = {1'b0, last_q} + (IDX_WIDTH+1)'(k);
      if (cand_s >= NUM_M_W) begin
        cand_s = cand_s - NUM_M_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && m_cyc[cand_s[IDX_WIDTH-1:0]]) begin
        pick_s  = cand_s[IDX_WIDTH-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Watchdog fires on the stalled cycle in which the count would reach TIMEOUT.
  always_comb begin
    timeout_s = 1'b0;
    cnt_d     = {CNT_WIDTH{1'b0}};
    if (state_q == ST_BUSY && m_cyc[gidx_q]) begin
      if (resp_s || !m_stb[gidx_q]) begin
        cnt_d = {CNT_WIDTH{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
        timeout_s = 1'b1;
        cnt_d     = {CNT_WIDTH{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State, grant and last-owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= {NUM_MASTERS{1'b0}};
      gidx_q  <= {IDX_WIDTH{1'b0}};
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: grant is taken in IDLE and frozen until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d         = ST_BUSY;
          gidx_d          = pick_s;
          grant_d         = {NUM_MASTERS{1'b0}};
          grant_d[pick_s] = 1'b1;
        end else begin
          grant_d = {NUM_MASTERS{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!m_cyc[gidx_q] || timeout_s) begin
          state_d = ST_IDLE;
          grant_d = {NUM_MASTERS{1'b0}};
          last_d  = gidx_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_MASTERS{1'b0}};
      end
    endcase
  end

  // Output muxing: combinational from the registered owner so slave ack timing passes straight through.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = {ADR_WIDTH{1'b0}};
    s_dat_ms = {DATA_WIDTH{1'b0}};
    s_sel    = {SEL_WIDTH{1'b0}};
    s_cti    = 3'b000;
    s_bte    = 2'b00;
    m_ack    = {NUM_MASTERS{1'b0}};
    m_rty    = {NUM_MASTERS{1'b0}};
    m_err    = {NUM_MASTERS{1'b0}};
    if (rst_n && state_q == ST_BUSY) begin
      s_cyc         = m_cyc[gidx_q] & ~timeout_s;
      s_stb         = m_stb[gidx_q] & ~timeout_s;
      s_we          = m_we[gidx_q];
      s_adr         = m_adr[gidx_q*ADR_WIDTH +: ADR_WIDTH];
      s_dat_ms      = m_dat_ms[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      s_sel         = m_sel[gidx_q*SEL_WIDTH +: SEL_WIDTH];
      s_cti         = m_cti[gidx_q*3 +: 3];
      s_bte         = m_bte[gidx_q*2 +: 2];
      m_ack[gidx_q] = s_ack;
      m_rty[gidx_q] = s_rty;
      m_err[gidx_q] = s_err | timeout_s;
    end else begin
      s_cyc = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with two masters and TIMEOUT=8.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_ms;
  logic [N*4-1:0]  m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [N-1:0]    m_ack, m_rty, m_err;
  logic [DW-1:0]   m_dat_sm;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_ms;
  logic [3:0]      s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_ack, s_rty, s_err;
  logic [DW-1:0]   s_dat_sm;
  logic [N-1:0]    grant;

  int total = 0;
  int bad   = 0;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
    .m_ack(m_ack), .m_rty(m_rty), .m_err(m_err), .m_dat_sm(m_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_rty(s_rty), .s_err(s_err), .s_dat_sm(s_dat_sm),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[i]            = cyc;
    m_stb[i]            = stb;
    m_we[i]             = we;
    m_adr[i*AW +: AW]   = adr;
    m_dat_ms[i*DW +: DW] = dat;
    m_sel[i*4 +: 4]     = 4'hF;
    m_cti[i*3 +: 3]     = cti;
    m_bte[i*2 +: 2]     = 2'b00;
  endtask

  logic [1:0] exp_g;
  int         own;

  initial begin
    rst_n = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b00; m_we = 2'b00;
    m_adr = '0; m_dat_ms = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b1; s_rty = 1'b0; s_err = 1'b0; s_dat_sm = 32'h0;

    // Reset held for two edges with both masters requesting.
    @(negedge clk);
    nxt();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_cyc", 64'(s_cyc), 64'h0);
    chk("rst_m_ack", 64'(m_ack), 64'h0);
    rst_n = 1'b1;
    s_ack = 1'b0;
    settle();
    chk("rel_grant0", 64'(grant), 64'h0);

    // M0 wins (last starts at 1) and performs a single write with a same-cycle ack.
    nxt();
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 3'b000);
    s_ack = 1'b1; s_dat_sm = 32'h12345678;
    settle();
    chk("wr_grant", 64'(grant), 64'h1);
    chk("wr_s_cyc", 64'(s_cyc), 64'h1);
    chk("wr_s_stb", 64'(s_stb), 64'h1);
    chk("wr_s_we", 64'(s_we), 64'h1);
    chk("wr_s_adr", 64'(s_adr), 64'h10);
    chk("wr_s_dat", 64'(s_dat_ms), 64'hDEADBEEF);
    chk("wr_s_sel", 64'(s_sel), 64'hF);
    chk("wr_m_ack", 64'(m_ack), 64'h1);
    chk("wr_m_dat_sm", 64'(m_dat_sm), 64'h12345678);

    // M0 releases; no strobe that cycle, then one IDLE cycle, then M1.
    nxt();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack = 1'b0;
    settle();
    chk("rel_grant", 64'(grant), 64'h1);
    chk("rel_s_cyc", 64'(s_cyc), 64'h0);
    chk("rel_m_ack", 64'(m_ack), 64'h0);
    nxt();
    chk("idle_grant", 64'(grant), 64'h0);
    chk("idle_s_stb", 64'(s_stb), 64'h0);
    nxt();
    chk("m1_grant", 64'(grant), 64'h2);

    // M1 4-beat incrementing burst read while M0 waits.
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55, 3'b000);
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h40 + 32'(4*i), 32'h0, (i == 3) ? 3'b111 : 3'b010);
      s_ack = 1'b1; s_dat_sm = 32'hA0 + 32'(i);
      settle();
      chk("bst_grant", 64'(grant), 64'h2);
      chk("bst_s_adr", 64'(s_adr), 64'h40 + 64'(4*i));
      chk("bst_s_cti", 64'(s_cti), (i == 3) ? 64'h7 : 64'h2);
      chk("bst_s_we", 64'(s_we), 64'h0);
      chk("bst_m_ack", 64'(m_ack), 64'h2);
      chk("bst_m_dat", 64'(m_dat_sm), 64'hA0 + 64'(i));
      nxt();
    end
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack = 1'b0;
    settle();
    chk("bst_end_grant", 64'(grant), 64'h2);
    chk("bst_end_s_cyc", 64'(s_cyc), 64'h0);
    nxt();
    chk("bst_idle_grant", 64'(grant), 64'h0);
    m_stb = 2'b00;
    m_cyc[1] = 1'b1;
    nxt();
    chk("post_bst_grant", 64'(grant), 64'h1);

    // Fairness: owner does one transfer, drops cyc, re-requests in the IDLE cycle.
    exp_g = 2'b01;
    for (int t = 0; t < 8; t++) begin
      own = (exp_g == 2'b01) ? 0 : 1;
      m_stb[own] = 1'b1;
      s_ack = 1'b1;
      settle();
      chk("fair_grant", 64'(grant), 64'(exp_g));
      chk("fair_m_ack", 64'(m_ack), 64'(exp_g));
      nxt();
      m_cyc[own] = 1'b0; m_stb[own] = 1'b0;
      s_ack = 1'b0;
      nxt();
      m_cyc[own] = 1'b1;
      settle();
      chk("fair_idle", 64'(grant), 64'h0);
      nxt();
      exp_g = ~exp_g;
    end

    // Hung slave: M0 strobes with no response.
    m_stb[0] = 1'b1; m_we[0] = 1'b0;
    s_ack = 1'b0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      settle();
      if (k < 8) begin
        chk("to_wait_err", 64'(m_err), 64'h0);
        chk("to_wait_stb", 64'(s_stb), 64'h1);
      end else begin
        chk("to_fire_err", 64'(m_err), 64'h1);
        chk("to_fire_cyc", 64'(s_cyc), 64'h0);
        chk("to_fire_stb", 64'(s_stb), 64'h0);
      end
      nxt();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    chk("to_idle_grant", 64'(grant), 64'h0);
    chk("to_idle_err", 64'(m_err), 64'h0);
    nxt();
    chk("to_next_grant", 64'(grant), 64'h2);
`else
    for (int k = 1; k <= 12; k++) begin
      settle();
      chk("hang_err", 64'(m_err), 64'h0);
      chk("hang_stb", 64'(s_stb), 64'h1);
      chk("hang_grant", 64'(grant), 64'h1);
      nxt();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    settle();
    chk("hang_rel_err", 64'(m_err), 64'h0);
    nxt();
    chk("hang_idle_grant", 64'(grant), 64'h0);
    nxt();
    chk("hang_next_grant", 64'(grant), 64'h2);
`endif

    // Retry routing, then reset mid-transfer drops the bus immediately.
    m_stb[1] = 1'b1; m_we[1] = 1'b1;
    s_rty = 1'b1;
    settle();
    chk("rty_route", 64'(m_rty), 64'h2);
    chk("rty_s_stb", 64'(s_stb), 64'h1);
    s_rty = 1'b0;
    rst_n = 1'b0;
    settle();
    chk("mid_rst_cyc", 64'(s_cyc), 64'h0);
    chk("mid_rst_stb", 64'(s_stb), 64'h0);
    nxt();
    chk("mid_rst_grant", 64'(grant), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
